// File: rtl/bbqm_pkg.sv
// rtl/bbqm_pkg.sv - door FSM state encoding and direction constants
package bbqm_pkg;

   typedef enum logic [3:0] {
      ST_IDLE     = 4'd0,
      ST_ENT_A    = 4'd1,
      ST_ENT_AB   = 4'd2,
      ST_ENT_B    = 4'd3,
      ST_EXT_A    = 4'd4,
      ST_EXT_AB   = 4'd5,
      ST_EXT_B    = 4'd6,
      ST_WAIT_CLR = 4'd7,
      ST_FAULT    = 4'd8
   } door_state_t;

   localparam logic DIR_UP   = 1'b1;
   localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/sensor_debounce.sv
// rtl/sensor_debounce.sv - photocell synchroniser and debounce filter
// Filtered level follows the synced input only after DB_LIMIT consecutive mismatching cycles.
module sensor_debounce #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned DB_W        = 16,
   parameter int unsigned DB_LIMIT    = 50000
) (
   input  logic clk,
   input  logic reset,
   input  logic i_async,
   output logic o_level
);

   logic [SYNC_STAGES-1:0] r_sync;
   logic [DB_W-1:0]        r_cnt;
   logic                   r_level;
   logic                   w_synced;

   assign w_synced = r_sync[SYNC_STAGES-1];
   assign o_level  = r_level;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sync <= '0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_level <= 1'b0;
         r_cnt   <= '0;
      end else if (w_synced != r_level) begin
         if (r_cnt == DB_W'(DB_LIMIT - 1)) begin
            r_level <= w_synced;
            r_cnt   <= '0;
         end else begin
            r_cnt <= r_cnt + DB_W'(1);
         end
      end else begin
         r_cnt <= '0;
      end
   end

endmodule

// File: rtl/queue_door_sensor.sv
// rtl/queue_door_sensor.sv - door photocell direction decoder for the queue counter
// Two filtered beams drive a passage FSM; a completed passage yields one step strobe plus direction.
module queue_door_sensor
   import bbqm_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned DB_W        = 16,
   parameter int unsigned DB_LIMIT    = 50000,
   parameter int unsigned TO_W        = 28,
   parameter int unsigned TO_CYC      = 150000000
) (
   input  logic clk,
   input  logic reset,
   input  logic sens_outer,
   input  logic sens_inner,
   output logic cnt_step,
   output logic cnt_up,
   output logic busy,
   output logic sens_fault
);

   logic            w_o;
   logic            w_i;
   door_state_t     r_state;
   door_state_t     w_next;
   logic [TO_W-1:0] r_to_cnt;
   logic            w_timeout;
   logic            w_busy;
   logic            w_fault;
   logic            w_step_ev;
   logic            w_step_dir;
   logic            r_step;
   logic            r_up;

   sensor_debounce #(.SYNC_STAGES(SYNC_STAGES), .DB_W(DB_W), .DB_LIMIT(DB_LIMIT)) u_db_outer (
      .clk(clk), .reset(reset), .i_async(sens_outer), .o_level(w_o)
   );

   sensor_debounce #(.SYNC_STAGES(SYNC_STAGES), .DB_W(DB_W), .DB_LIMIT(DB_LIMIT)) u_db_inner (
      .clk(clk), .reset(reset), .i_async(sens_inner), .o_level(w_i)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Timeout has priority so a wedged passage cannot also emit a step in the same cycle.
   always_comb begin
      w_next = r_state;
      if (w_timeout) begin
         w_next = ST_FAULT;
      end else begin
         unique case (r_state)
            ST_IDLE: begin
               if (w_o && !w_i)      w_next = ST_ENT_A;
               else if (!w_o && w_i) w_next = ST_EXT_A;
               else if (w_o && w_i)  w_next = ST_WAIT_CLR;
            end
            ST_ENT_A: begin
               if (w_o && w_i)        w_next = ST_ENT_AB;
               else if (!w_o && !w_i) w_next = ST_IDLE;
               else if (!w_o && w_i)  w_next = ST_WAIT_CLR;
            end
            ST_ENT_AB: begin
               if (!w_o && w_i)       w_next = ST_ENT_B;
               else if (w_o && !w_i)  w_next = ST_ENT_A;
               else if (!w_o && !w_i) w_next = ST_IDLE;
            end
            ST_ENT_B: begin
               if (!w_o && !w_i)     w_next = ST_IDLE;
               else if (w_o && w_i)  w_next = ST_ENT_AB;
               else if (w_o && !w_i) w_next = ST_WAIT_CLR;
            end
            ST_EXT_A: begin
               if (w_o && w_i)        w_next = ST_EXT_AB;
               else if (!w_o && !w_i) w_next = ST_IDLE;
               else if (w_o && !w_i)  w_next = ST_WAIT_CLR;
            end
            ST_EXT_AB: begin
               if (w_o && !w_i)       w_next = ST_EXT_B;
               else if (!w_o && w_i)  w_next = ST_EXT_A;
               else if (!w_o && !w_i) w_next = ST_IDLE;
            end
            ST_EXT_B: begin
               if (!w_o && !w_i)     w_next = ST_IDLE;
               else if (w_o && w_i)  w_next = ST_EXT_AB;
               else if (!w_o && w_i) w_next = ST_WAIT_CLR;
            end
            ST_WAIT_CLR, ST_FAULT: begin
               if (!w_o && !w_i) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      w_busy     = (r_state != ST_IDLE) && (r_state != ST_FAULT);
      w_fault    = (r_state == ST_FAULT);
      w_step_ev  = ((r_state == ST_ENT_B) || (r_state == ST_EXT_B)) && (w_next == ST_IDLE);
      w_step_dir = (r_state == ST_ENT_B) ? DIR_UP : DIR_DOWN;
   end

   assign w_timeout = w_busy && (r_to_cnt == TO_W'(TO_CYC));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_to_cnt <= '0;
      end else if ((w_next != r_state) || !w_busy) begin
         r_to_cnt <= '0;
      end else begin
         r_to_cnt <= r_to_cnt + TO_W'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_step <= 1'b0;
         r_up   <= DIR_UP;
      end else begin
         r_step <= w_step_ev;
         if (w_step_ev) r_up <= w_step_dir;
      end
   end

   assign cnt_step   = r_step;
   assign cnt_up     = r_up;
   assign busy       = w_busy;
   assign sens_fault = w_fault;

endmodule
